conv_deinterleave_core: RTL and testbench
=========================================

// Module: conv_deinterleave_core
// PURPOSE
//  Forney convolutional de-interleaver (I=12, M=17): the receive-side inverse of interleave_top.
//  Byte stream in, each byte with a sync flag, I branches visited cyclically.
//  Branch j delays by (I-1-j)*M branch-visits; end-to-end delay with the interleaver is I*(I-1)*M = 2244 bytes.
//  Restores the original 204-byte frame order and re-marks the frame sync byte.
// PARAMETERS
//  I_BR       12   number of branches
//  M_DEPTH    17   delay unit per branch, in bytes
//  FRAME_LEN  204  frame length; must equal k*I_BR
//  DW         8    data byte width
// PORTS
//  clk        in   1    single clock; all logic rising-edge
//  rst        in   1    synchronous, active-high reset
//  din        in   DW   interleaved byte
//  din_valid  in   1    byte accepted when high; nothing advances when low
//  syn_in     in   1    qualified by din_valid; marks an interleaved sync byte, which is always on branch 0
//  dout       out  DW   de-interleaved byte
//  dout_valid out  1    dout/syn_out valid
//  syn_out    out  1    dout is a frame sync byte
//  lock       out  1    delay lines filled and aligned
//  sync_err   out  1    one-cycle pulse: syn_in seen while branch index != 0
// BEHAVIOUR
//  - Reset: dout=0, dout_valid=0, syn_out=0, lock=0, sync_err=0, branch=0, base=0, all branch pointers=0, fill=0.
//    RAM contents are not cleared. Reset wins over a simultaneous din_valid.
//  - Storage: one RAM of M*I*(I-1)/2 = 1122 words x (DW+1); word = {sync flag, byte}.
//    Branch j owns D_j=(I-1-j)*M words at base B_j = sum_{k<j} D_k.
//  - Per accepted byte on branch j<I-1: read-before-write at B_j+ptr[j]. Old word -> output register; {syn_in,din} written.
//    ptr[j] wraps D_j-1 -> 0.
//  - Branch I-1 (D=0): bypass. {syn_in,din} goes straight to the output register.
//  - Latency: output register updates exactly 1 cycle after the accepting din_valid cycle.
//  - Branch advance: branch = (branch==I-1) ? 0 : branch+1; base += D_branch, cleared when branch wraps to 0.
//  - fill: 12-bit counter of accepted bytes since reset/resync, saturating at I*(I-1)*M = 2244.
//    lock = (fill==2244).
//  - Before lock: dout updates, but dout_valid=0 and syn_out=0.
//  - Once locked: dout_valid = registered din_valid; syn_out = stored flag AND source branch == 0.
//  - Resync: syn_in & din_valid & branch!=0 ->
//    - sync_err pulses next cycle;
//    - byte is treated as branch 0 (branch, base realigned);
//    - fill=0 and lock drops next cycle;
//    - pointers are kept.
//  - syn_in with branch==0 is normal; no action.
// CONFIGURATION
//  - DEINT_ERR_CNT_EN defined: adds output err_cnt[15:0].
//    - Counts sync_err pulses, saturating at 16'hFFFF.
//    - Synchronous reset to 0.
//  - Undefined: port and counter absent; sync_err still present.
// STRUCTURE
//  - Shared package deint_pkg:
//    - I_BR, M_DEPTH, FRAME_LEN, RAM_DEPTH (1122), FILL_MAX (2244);
//    - constant function depth_of(j) and base_of(j);
//    - word typedef {sync, byte}.
//  - One sub-module deint_ram: single-port, read-before-write, 1-cycle read, inferred block RAM, width DW+1.
//  - Top holds branch/base/pointer/fill control and the output register.
// TESTING
//  1. Loopback: interleave_top -> this block, source bytes 0..203 repeating, sync on byte 0.
//     -> After lock, dout is 0,1,..,203 in order, syn_out on every dout==0, no sync_err.
//  2. Latency: a byte on branch 11 -> the same byte on dout the next cycle.
//     A byte on branch 0 reappears after 187 further branch-0 visits (2244 accepted bytes).
//  3. Gaps: din_valid low on random cycles (~30%).
//     -> Output sequence identical to test 1; dout_valid only on cycles following accepted bytes.
//  4. Misalignment: once locked, assert syn_in on branch 5.
//     -> sync_err=1 for one cycle, lock=0, realigned.
//     -> lock returns after 2244 bytes; err_cnt=1 when DEINT_ERR_CNT_EN is defined.
//  5. Reset mid-stream: rst=1 for 3 cycles at byte 3000.
//     -> All outputs 0 next cycle, lock=0, lock back after 2244 bytes.
//     -> No false syn_out from stale RAM flags.
//  6. Counter saturation (DEINT_ERR_CNT_EN): force err_cnt to 16'hFFFE, then inject 3 misaligned syncs.
//     -> err_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/deint_pkg.sv
// Shared constants, storage word type and branch geometry helpers for the
// I=12 / M=17 Forney convolutional de-interleaver.
package deint_pkg;

  localparam int I_BR      = 12;
  localparam int M_DEPTH   = 17;
  localparam int FRAME_LEN = 204;
  localparam int DW        = 8;
  localparam int RAM_DEPTH = M_DEPTH * I_BR * (I_BR - 1) / 2;
  localparam int FILL_MAX  = I_BR * (I_BR - 1) * M_DEPTH;

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int BW = $clog2(I_BR);
  localparam int PW = $clog2((I_BR - 1) * M_DEPTH);
  localparam int FW = 12;

  typedef struct packed {
    logic          sync;
    logic [DW-1:0] data;
  } word_t;

  function automatic int depth_of(input int j);
    return (I_BR - 1 - j) * M_DEPTH;
  endfunction

  function automatic int base_of(input int j);
    int b;
    b = 0;
    for (int k = 0; k < j; k++) b += depth_of(k);
    return b;
  endfunction

endpackage

// File: rtl/deint_ram.sv
// Single-port read-before-write RAM holding every branch delay line.
// One-cycle registered read; contents are never cleared.
module deint_ram
  import deint_pkg::*;
(
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  word_t         wdata_i,
  output word_t         rdata_o
);

  word_t mem [RAM_DEPTH];
  word_t rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q      <= mem[addr_i];
      mem[addr_i]  <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_deinterleave_core.sv
// Forney convolutional de-interleaver: branch/base/pointer/fill control plus output register.
// Optional DEINT_ERR_CNT_EN adds a saturating sync-error counter on err_cnt.
module conv_deinterleave_core
  import deint_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          syn_in,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          syn_out,
  output logic          lock,
  output logic          sync_err
`ifdef DEINT_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  logic [BW-1:0] branch_q, branch_d, cur_br;
  logic [AW-1:0] base_q, base_d, cur_base, ram_addr;
  logic [PW-1:0] ptr_q [I_BR];
  logic [PW-1:0] ptr_d [I_BR];
  logic [FW-1:0] fill_q, fill_d;
  logic          accept, resync, bypass, ram_en;
  logic [DW-1:0] byp_data_q;
  logic          out_byp_q, out_zero_q, syn_gate_q, dout_valid_q, sync_err_q;
  word_t         ram_wdata, ram_rdata;

  assign lock   = (fill_q == FW'(FILL_MAX));
  assign accept = din_valid & ~rst;
  // A sync byte off branch 0 forces this byte to be handled as branch 0.
  assign resync   = accept & syn_in & (branch_q != '0);
  assign cur_br   = resync ? '0 : branch_q;
  assign cur_base = resync ? '0 : base_q;
  assign bypass   = (cur_br == BW'(I_BR - 1));
  assign ram_addr = cur_base + AW'(ptr_q[cur_br]);
  assign ram_en   = accept & ~bypass;
  assign ram_wdata = {syn_in, din};

  deint_ram u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    branch_d = branch_q;
    base_d   = base_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    if (accept) begin
      if (bypass) begin
        branch_d = '0;
        base_d   = '0;
      end else begin
        branch_d = cur_br + 1'b1;
        base_d   = cur_base + AW'(depth_of(int'(cur_br)));
        ptr_d[cur_br] = (ptr_q[cur_br] == PW'(depth_of(int'(cur_br)) - 1)) ? '0
                                                                           : ptr_q[cur_br] + 1'b1;
      end
      if (resync)
        fill_d = '0;
      else if (!lock)
        fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_q     <= '0;
      base_q       <= '0;
      fill_q       <= '0;
      for (int k = 0; k < I_BR; k++) ptr_q[k] <= '0;
      byp_data_q   <= '0;
      out_byp_q    <= 1'b0;
      out_zero_q   <= 1'b1;
      syn_gate_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      branch_q     <= branch_d;
      base_q       <= base_d;
      fill_q       <= fill_d;
      ptr_q        <= ptr_d;
      dout_valid_q <= accept & lock & ~resync;
      syn_gate_q   <= accept & lock & ~resync & (cur_br == '0);
      sync_err_q   <= resync;
      if (accept) begin
        out_zero_q <= 1'b0;
        out_byp_q  <= bypass;
        if (bypass) byp_data_q <= din;
      end
    end
  end

  // Stale RAM data is hidden after reset until the first accepted byte.
  assign dout       = out_zero_q ? '0 : (out_byp_q ? byp_data_q : ram_rdata.data);
  assign syn_out    = syn_gate_q & ram_rdata.sync;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;

`ifdef DEINT_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= '0;
    else if (resync && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_conv_deinterleave_core.sv
// Randomized bench: queue-based interleaver feeding the de-interleaver, checked
// against a per-branch FIFO model plus literal end-to-end frame-order expectations.
module tb_conv_deinterleave_core;

  localparam int NB   = 12;
  localparam int MD   = 17;
  localparam int FILL = 2244;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       syn_in;
  logic [7:0] dout;
  logic       dout_valid;
  logic       syn_out;
  logic       lock;
  logic       sync_err;
`ifdef DEINT_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  conv_deinterleave_core dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .syn_in     (syn_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .syn_out    (syn_out),
    .lock       (lock),
    .sync_err   (sync_err)
`ifdef DEINT_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // de-interleaver model: one FIFO per branch holding exactly its delay
  bit [8:0] mq [NB][$];
  int       m_br, m_fill, m_errcnt;
  bit [7:0] e_dout, e_pin;
  bit       e_known, e_valid, e_syn, e_lock, e_err, e_pin_en;
  bit       started = 1'b0;

  // interleaver model feeding the bench stream
  bit [8:0] ilq [NB][$];
  int       il_br, il_idx;

  function automatic int dly(input int j);
    return (NB - 1 - j) * MD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit [7:0] d, input bit s,
                      input bit pin_ok, input bit [7:0] pin);
    bit       rs;
    bit       was_lock;
    int       br;
    bit [8:0] w, o;
    if (started) begin
      chk("dout_valid", dout_valid, e_valid);
      chk("syn_out", syn_out, e_syn);
      chk("lock", lock, e_lock);
      chk("sync_err", sync_err, e_err);
      if (e_known) chk("dout", dout, e_dout);
      if (e_pin_en) begin
        chk("frame_byte", dout, e_pin);
        chk("frame_sync", syn_out, e_pin == 8'd0);
      end
`ifdef DEINT_ERR_CNT_EN
      chk("err_cnt", err_cnt, m_errcnt);
`endif
    end
    started = 1'b1;
    rst = r; din_valid = v; din = d; syn_in = s;
    if (r) begin
      m_br = 0; m_fill = 0; m_errcnt = 0;
      for (int j = 0; j < NB; j++) mq[j].delete();
      e_dout = 8'd0; e_known = 1'b1; e_valid = 1'b0; e_syn = 1'b0;
      e_lock = 1'b0; e_err = 1'b0; e_pin_en = 1'b0;
    end else if (v) begin
      rs       = s && (m_br != 0);
      was_lock = (m_fill == FILL);
      if (rs) m_br = 0;
      br = m_br;
      w  = {s, d};
      o  = 9'd0;
      if (dly(br) == 0) begin
        o = w; e_known = 1'b1;
      end else begin
        e_known = (mq[br].size() == dly(br));
        if (e_known) o = mq[br].pop_front();
        mq[br].push_back(w);
      end
      e_dout   = o[7:0];
      e_valid  = was_lock && !rs;
      e_syn    = e_valid && (br == 0) && o[8];
      e_err    = rs;
      if (rs && m_errcnt < 16'hFFFF) m_errcnt++;
      m_fill   = rs ? 0 : ((m_fill < FILL) ? m_fill + 1 : FILL);
      e_lock   = (m_fill == FILL);
      m_br     = (br == NB - 1) ? 0 : br + 1;
      e_pin_en = e_valid && pin_ok;
      e_pin    = pin;
    end else begin
      e_valid = 1'b0; e_syn = 1'b0; e_err = 1'b0; e_pin_en = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of the loopback stream: source bytes 0..203 repeating, sync on byte 0.
  task automatic feed_il(input int gap_pct, input bit force_sync);
    bit [8:0] w, o;
    int       pv;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      step(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b0, 8'd0);
      return;
    end
    w = {(il_idx % 204) == 0, 8'(il_idx % 204)};
    if (il_br == 0) o = w;
    else begin
      ilq[il_br].push_back(w);
      o = ilq[il_br].pop_front();
    end
    pv = (il_idx >= FILL) ? (il_idx - FILL) % 204 : 0;
    step(1'b0, 1'b1, o[7:0], o[8] | force_sync, il_idx >= FILL, 8'(pv));
    il_idx++;
    il_br = (il_br == NB - 1) ? 0 : il_br + 1;
  endtask

  task automatic feed_rand(input bit [7:0] d, input bit s);
    for (int g = 0; g < 4 && $urandom_range(99) < 30; g++)
      step(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b0, 8'd0);
    step(1'b0, 1'b1, d, s, 1'b0, 8'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 8'd0; syn_in = 1'b0;
    il_br = 0; il_idx = 0;
    for (int j = 1; j < NB; j++)
      for (int k = 0; k < j * MD; k++) ilq[j].push_back(9'd0);
    @(negedge clk);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);

    // Loopback with ~30% gaps up to byte 3000, then reset mid-stream.
    for (int n = 0; n < 20000 && il_idx < 3000; n++) feed_il(30, 1'b0);
    chk("lock_before_reset", lock, 1'b1);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    chk("rst_dout", dout, 8'd0);
    chk("rst_lock", lock, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    for (int n = 0; n < 6000 && !lock; n++) feed_il(30, 1'b0);
    chk("relock_after_reset", lock, 1'b1);
    for (int n = 0; n < 600; n++) feed_il(30, 1'b0);

    // Misaligned sync on branch 5 while locked.
    for (int n = 0; n < 12 && m_br != 5; n++) feed_il(0, 1'b0);
    feed_il(0, 1'b1);
    chk("misalign_err", sync_err, 1'b1);
    chk("misalign_lock", lock, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    chk("err_pulse_len", sync_err, 1'b0);
    for (int n = 0; n < 6000 && !lock; n++) feed_il(30, 1'b0);
    chk("relock_after_resync", lock, 1'b1);
    for (int n = 0; n < 400; n++) feed_il(30, 1'b0);

    // Random bytes: bypass latency and full branch-0 delay.
    for (int n = 0; n < 24 && m_br != NB - 1; n++) feed_rand(8'($urandom), 1'b0);
    feed_rand(8'h5A, 1'b0);
    chk("lat_br11", dout, 8'h5A);
    chk("lat_br11_valid", dout_valid, 1'b1);
    for (int n = 0; n < 24 && m_br != 0; n++) feed_rand(8'($urandom), 1'b0);
    feed_rand(8'hC3, 1'b0);
    for (int n = 0; n < FILL - 1; n++) feed_rand(8'($urandom), 1'b0);
    feed_rand(8'h00, 1'b0);
    chk("br0_delay", dout, 8'hC3);
    chk("br0_delay_valid", dout_valid, 1'b1);

`ifdef DEINT_ERR_CNT_EN
    force dut.err_cnt_q = 16'hFFFE;
    m_errcnt = 16'hFFFE;
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    release dut.err_cnt_q;
    for (int e = 0; e < 3; e++) begin
      for (int n = 0; n < 4 && m_br == 0; n++) feed_rand(8'($urandom), 1'b0);
      feed_rand(8'($urandom), 1'b1);
    end
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    chk("err_cnt_sat", err_cnt, 16'hFFFF);
`endif

    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
